// File: rtl/boot_pkg.sv
// Shared constants for the MCU boot loader: FSM encoding, error codes, RAM direction.
// Optional trailer checksum is enabled with BOOT_CHECKSUM_EN.
package boot_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_CHK    = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_ERROR  = 3'd7;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_MOC  = 2'b10;
   localparam logic [1:0] ERR_CHK  = 2'b11;

   localparam logic MEM_RW_WRITE = 1'b0;
   localparam logic MEM_RW_READ  = 1'b1;

   // States in which a stream byte may be consumed
   function automatic logic st_ready(input logic [2:0] st);
      return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) || (st == ST_CHK);
   endfunction

   function automatic logic st_busy(input logic [2:0] st);
      return st_ready(st) || (st == ST_WRITE);
   endfunction

endpackage

// File: rtl/mcu_boot_loader_if.sv
// Stream-in and RAM-write handshake bundle of the boot loader.
// master = loader side, slave = stream source / RAM side.
interface mcu_boot_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              S_VALID;
   logic [7:0]        S_DATA;
   logic              S_READY;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [7:0]        MEM_DIN;
   logic              MEM_EN;
   logic              MEM_RW;
   logic              MEM_MOC;

   modport master (
      input  S_VALID, S_DATA, MEM_MOC,
      output S_READY, MEM_ADDR, MEM_DIN, MEM_EN, MEM_RW
   );

   modport slave (
      output S_VALID, S_DATA, MEM_MOC,
      input  S_READY, MEM_ADDR, MEM_DIN, MEM_EN, MEM_RW
   );
endinterface

// File: rtl/boot_moc_timer.sv
// Counts WRITE cycles without MEM_MOC; expired flags the cycle whose edge reaches MOC_TIMEOUT.
module boot_moc_timer #(
   parameter int unsigned MOC_TIMEOUT = 15
) (
   input  logic CLK,
   input  logic RESET,
   input  logic run,
   input  logic clr,
   output logic expired
);
   localparam int unsigned CNT_W = $clog2(MOC_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (RESET || clr) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Combinational so the FSM leaves WRITE on the very edge the count would hit the limit
   assign expired = run && (cnt_q == CNT_W'(MOC_TIMEOUT - 1));

endmodule

// File: rtl/mcu_boot_loader.sv
// Length-prefixed byte stream loader into program RAM; holds the core in reset until loaded.
// Define BOOT_CHECKSUM_EN to require a trailing checksum byte after the payload.
module mcu_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned MOC_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   mcu_boot_loader_if.master bus,
   output logic              CPU_RESET,
   output logic              BUSY,
   output logic              DONE,
   output logic [1:0]        ERR,
   output logic [ADDR_W:0]   BYTE_CNT
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned ROOM  = DEPTH - BASE_ADDR;

`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] ST_PAYLOAD_END = ST_CHK;
`else
   localparam logic [2:0] ST_PAYLOAD_END = ST_DONE;
`endif

   logic [2:0]        state_q, state_d;
   logic [15:0]       len_q, len_d, len_new;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        err_q, err_d;
   logic              s_ready_q, mem_en_q, mem_rw_q, cpu_reset_q, busy_q, done_q;
   logic              accept, moc_run, moc_expired;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   assign accept  = s_ready_q && bus.S_VALID;
   assign moc_run = (state_q == ST_WRITE) && !bus.MEM_MOC;

   boot_moc_timer #(
      .MOC_TIMEOUT (MOC_TIMEOUT)
   ) u_moc_timer (
      .CLK     (CLK),
      .RESET   (RESET),
      .run     (moc_run),
      .clr     (!moc_run),
      .expired (moc_expired)
   );

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      din_d   = din_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      len_new = {bus.S_DATA, len_q[7:0]};
`ifdef BOOT_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (START) begin
               state_d = ST_LEN_LO;
               cnt_d   = '0;
               err_d   = ERR_NONE;
`ifdef BOOT_CHECKSUM_EN
               sum_d   = 8'h00;
`endif
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_d   = {len_q[15:8], bus.S_DATA};
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_d = len_new;
               if (32'(len_new) > ROOM) begin
                  state_d = ST_ERROR;
                  err_d   = ERR_LEN;
               end else if (len_new == 16'd0) begin
                  state_d = ST_PAYLOAD_END;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               din_d   = bus.S_DATA;
               addr_d  = ADDR_W'(BASE_ADDR + 32'(cnt_q));
               state_d = ST_WRITE;
`ifdef BOOT_CHECKSUM_EN
               sum_d   = 8'(sum_q + bus.S_DATA);
`endif
            end
         end
         ST_WRITE: begin
            if (bus.MEM_MOC) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (32'(cnt_q) + 32'd1 == 32'(len_q)) ? ST_PAYLOAD_END : ST_DATA;
            end else if (moc_expired) begin
               state_d = ST_ERROR;
               err_d   = ERR_MOC;
            end
         end
`ifdef BOOT_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               if (8'(sum_q + bus.S_DATA) == 8'h00) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = ERR_CHK;
               end
            end
         end
`endif
         ST_DONE: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; control outputs are registered copies of the next-state decode
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         addr_q      <= '0;
         din_q       <= '0;
         cnt_q       <= '0;
         err_q       <= ERR_NONE;
         s_ready_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= MEM_RW_READ;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         sum_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         s_ready_q   <= st_ready(state_d);
         mem_en_q    <= (state_d == ST_WRITE);
         mem_rw_q    <= (state_d == ST_WRITE) ? MEM_RW_WRITE : MEM_RW_READ;
         cpu_reset_q <= (state_d != ST_DONE);
         busy_q      <= st_busy(state_d);
         done_q      <= (state_d == ST_DONE);
`ifdef BOOT_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign bus.S_READY  = s_ready_q;
   assign bus.MEM_ADDR = addr_q;
   assign bus.MEM_DIN  = din_q;
   assign bus.MEM_EN   = mem_en_q;
   assign bus.MEM_RW   = mem_rw_q;
   assign CPU_RESET    = cpu_reset_q;
   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign ERR          = err_q;
   assign BYTE_CNT     = cnt_q;

endmodule

// File: doc/mcu_boot_loader.md
Name: mcu_boot_loader

Overview:
- Synthesizable replacement for behavioural RAM pre-charge: receives a length-prefixed byte stream and writes it into the byte-wide program RAM through the MOC memory handshake.
- Holds the MCU core in reset (CPU_RESET) until the image is fully written, then releases it.
- Sits between the external load port and the RAM port of datapath_pepo.
- Generalised in address width, RAM depth, base address and write timeout.

Parameters:
ADDR_W, 8, RAM address width in bits.
DEPTH, 256, RAM size in bytes; must be ≤ 2^ADDR_W.
BASE_ADDR, 0, first RAM address written.
MOC_TIMEOUT, 15, max cycles to wait for MEM_MOC per write; must be ≥ 1.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
START  in  1  single-cycle pulse; begins a load.
S_VALID  in  1  stream byte valid.
S_DATA  in  8  stream byte.
S_READY  out  1  loader accepts the byte; transfer occurs when S_VALID && S_READY at a rising edge.
MEM_ADDR  out  ADDR_W  RAM byte address.
MEM_DIN  out  8  RAM write data.
MEM_EN  out  1  memory request.
MEM_RW  out  1  RAM direction: 0 = write, 1 = read. The loader only writes.
MEM_MOC  in  1  memory operation complete.
CPU_RESET  out  1  reset to the MCU core; 1 = held in reset.
BUSY  out  1  high while a load is in progress.
DONE  out  1  image loaded; core running.
ERR  out  2  error code: 00 none, 01 length overflow, 10 MOC timeout, 11 checksum error.
BYTE_CNT  out  ADDR_W+1  payload bytes written so far.

Behaviour:
- Reset state, applied the cycle after RESET is sampled high:
  - state IDLE; CPU_RESET=1; S_READY=0; MEM_EN=0; MEM_RW=1; MEM_ADDR=0; MEM_DIN=0.
  - BUSY=0; DONE=0; ERR=00; BYTE_CNT=0; LEN=0; timeout counter=0.
- RESET asserted mid-load aborts immediately: no further MEM_EN, CPU_RESET stays 1, partial RAM contents are left as written.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR. S_READY=1 only in LEN_LO, LEN_HI, DATA and CHK. All outputs are registered.
- IDLE:
  - START → LEN_LO; BUSY=1, BYTE_CNT=0, ERR=00.
  - START while BUSY or in DONE is ignored.
- LEN_LO: an accepted byte goes to LEN[7:0] → LEN_HI.
- LEN_HI: an accepted byte goes to LEN[15:8]. Then:
  - if LEN > DEPTH-BASE_ADDR → ERROR, ERR=01;
  - else if LEN == 0 → DONE (or CHK if the feature is enabled);
  - else → DATA.
- DATA, on an accepted byte:
  - MEM_DIN=byte; MEM_ADDR=(BASE_ADDR+BYTE_CNT) mod 2^ADDR_W; MEM_EN=1; MEM_RW=0.
  - S_READY drops; state → WRITE. MEM_EN rises the cycle after acceptance.
- WRITE: MEM_EN, MEM_ADDR and MEM_DIN are held stable.
  - MEM_MOC=1 → MEM_EN=0, MEM_RW=1, BYTE_CNT+1, timeout counter cleared. Then:
    - if BYTE_CNT+1 == LEN → DONE (or CHK if enabled);
    - else → DATA.
  - MEM_MOC=1 on the first WRITE cycle is legal; minimum is 2 cycles per byte.
  - Timeout counter increments each WRITE cycle without MOC. After MOC_TIMEOUT cycles without MOC → ERROR, ERR=10, MEM_EN=0.
- DONE: CPU_RESET=0, DONE=1, BUSY=0. Held until RESET.
- ERROR: CPU_RESET=1, BUSY=0, ERR held.
  - START → LEN_LO, ERR cleared, BYTE_CNT=0.
- S_VALID with S_READY=0 is not consumed; the stream stays stalled.

Optional Feature:
Macro BOOT_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum accumulates every payload byte; it is cleared on START.
  - CHK accepts one trailer byte. If (sum + trailer) mod 256 == 0 → DONE, else → ERROR with ERR=11.
  - LEN == 0 still requires the trailer; trailer 0x00 passes.
- Undefined:
  - No CHK state and no sum register; no trailer byte is consumed.
  - ERR=11 is never produced.

Decomposition:
- Package boot_pkg:
  - state encoding constants (3-bit);
  - ERR code constants (ERR_NONE, ERR_LEN, ERR_MOC, ERR_CHK);
  - MEM_RW_WRITE=0 and MEM_RW_READ=1.
- Sub-module boot_moc_timer:
  - parametrised by MOC_TIMEOUT;
  - inputs CLK, RESET, run, clr; output expired.

Test Plan:
- LEN=4, bytes 11 22 33 44, MOC 1 cycle after each MEM_EN → RAM[0..3]=11,22,33,44; BYTE_CNT=4; DONE=1; CPU_RESET falls 1 cycle after the 4th MOC.
- LEN=257, DEPTH=256 → ERROR with ERR=01, zero MEM_EN pulses, CPU_RESET=1. Then START with LEN=1 → recovers to DONE.
- MOC never returned on the 2nd byte, MOC_TIMEOUT=15 → ERR=10 exactly 15 cycles after MEM_EN rises; MEM_EN=0; BYTE_CNT=1.
- S_VALID toggled randomly, LEN=8 → stall then resume; all 8 bytes written in order, none duplicated or dropped.
- RESET pulsed during 3rd WRITE → all outputs at reset values the next cycle; a following START with LEN=2 completes normally.
- BOOT_CHECKSUM_EN: bytes 01 02 + trailer FD → DONE. Same with trailer FC → ERR=11, CPU_RESET=1.
